// File: rtl/upload_sequencer_if.sv
// ----------------------------------------------------------------------------
// upload_sequencer_if
//   Groups the host-side command/status signals and the switcher-side
//   handshake of the upload sequencer into one bundle.
//   master : host / upload switcher side (drives commands, trigger, data valid)
//   slave  : upload_sequencer (drives enable, trigger_start, status)
// Signals
//   run_start, run_abort, frame_num      host commands
//   laser_trig, upload_valid             trigger and per-word valid
//   fifo_prog_full                       host FIFO space indication
//   Upload_En, trigger_start             switcher control
//   busy, run_done, frames_sent          run progress
//   err_skip, err_overrun, err_timeout   sticky error flags
// ----------------------------------------------------------------------------
interface upload_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run_start;
  logic             run_abort;
  logic [CNT_W-1:0] frame_num;
  logic             laser_trig;
  logic             upload_valid;
  logic             fifo_prog_full;
  logic             Upload_En;
  logic             trigger_start;
  logic             busy;
  logic             run_done;
  logic [CNT_W-1:0] frames_sent;
  logic             err_skip;
  logic             err_overrun;
  logic             err_timeout;

  modport master (
    output run_start, run_abort, frame_num, laser_trig, upload_valid, fifo_prog_full,
    input  Upload_En, trigger_start, busy, run_done, frames_sent,
           err_skip, err_overrun, err_timeout
  );

  modport slave (
    input  run_start, run_abort, frame_num, laser_trig, upload_valid, fifo_prog_full,
    output Upload_En, trigger_start, busy, run_done, frames_sent,
           err_skip, err_overrun, err_timeout
  );
endinterface

// File: rtl/upload_sequencer.sv
// ----------------------------------------------------------------------------
// upload_sequencer
//   Run-level controller for the dual-channel overlapped-FFT upload path.
//   Sequences one run of frame_num frames: per frame it arms on the laser
//   trigger (if the host FIFO has room), pulses trigger_start, counts the
//   uploaded words, then holds a guard gap before re-arming. Reports
//   progress, completion and sticky error flags to the host.
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : upload_sequencer_if.slave (commands in, control/status out)
// All outputs are registered.
// ----------------------------------------------------------------------------
module upload_sequencer #(
  parameter int FRAME_LEN  = 512,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  upload_sequencer_if.slave     bus
);

  localparam int WORD_W = $clog2(FRAME_LEN);
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(FRAME_LEN - 1);
  // Timeout fires when the idle count would step onto TIMEOUT-1.
  localparam logic [IDLE_W-1:0] IDLE_ABORT = IDLE_W'(TIMEOUT - 2);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    UPLOAD = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  frame_num_r;
  logic [CNT_W-1:0]  frames_sent_r;
  logic [CNT_W-1:0]  frames_next_s;
  logic [WORD_W-1:0] word_cnt_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic              upload_en_r;
  logic              trigger_start_r;
  logic              busy_r;
  logic              run_done_r;
  logic              err_skip_r;
  logic              err_overrun_r;
  logic              err_timeout_r;

  // frames_sent never exceeds the latched count, so this cannot wrap.
  assign frames_next_s = frames_sent_r + CNT_W'(1'b1);

  // Run sequencer: state, counters and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      frame_num_r     <= {CNT_W{1'b0}};
      frames_sent_r   <= {CNT_W{1'b0}};
      word_cnt_r      <= {WORD_W{1'b0}};
      idle_cnt_r      <= {IDLE_W{1'b0}};
      gap_cnt_r       <= {GAP_W{1'b0}};
      upload_en_r     <= 1'b0;
      trigger_start_r <= 1'b0;
      busy_r          <= 1'b0;
      run_done_r      <= 1'b0;
      err_skip_r      <= 1'b0;
      err_overrun_r   <= 1'b0;
      err_timeout_r   <= 1'b0;
    end else begin
      trigger_start_r <= 1'b0;
      run_done_r      <= 1'b0;
      if ((state_r != IDLE) && bus.run_abort) begin
        // Abort outranks everything; counts and error flags are kept.
        state_r     <= IDLE;
        upload_en_r <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.run_start && !bus.run_abort) begin
              frame_num_r   <= bus.frame_num;
              frames_sent_r <= {CNT_W{1'b0}};
              err_skip_r    <= 1'b0;
              err_overrun_r <= 1'b0;
              err_timeout_r <= 1'b0;
              busy_r        <= 1'b1;
              if (bus.frame_num == {CNT_W{1'b0}}) begin
                state_r     <= DONE;
                upload_en_r <= 1'b0;
              end else begin
                state_r     <= ARM;
                upload_en_r <= 1'b1;
              end
            end
          end

          ARM: begin
            if (bus.laser_trig) begin
              if (bus.fifo_prog_full) begin
                err_skip_r <= 1'b1;
              end else begin
                trigger_start_r <= 1'b1;
                word_cnt_r      <= {WORD_W{1'b0}};
                idle_cnt_r      <= {IDLE_W{1'b0}};
                state_r         <= UPLOAD;
              end
            end
          end

          UPLOAD: begin
            if (bus.laser_trig) begin
              err_overrun_r <= 1'b1;
            end
            if (bus.upload_valid) begin
              idle_cnt_r <= {IDLE_W{1'b0}};
              if (word_cnt_r == WORD_LAST) begin
                word_cnt_r    <= {WORD_W{1'b0}};
                frames_sent_r <= frames_next_s;
                if (frames_next_s == frame_num_r) begin
                  state_r     <= DONE;
                  upload_en_r <= 1'b0;
                end else begin
                  state_r   <= GAP;
                  gap_cnt_r <= {GAP_W{1'b0}};
                end
              end else begin
                word_cnt_r <= word_cnt_r + WORD_W'(1'b1);
              end
            end else if (idle_cnt_r == IDLE_ABORT) begin
              // Stalled frame: abandon the run without counting it.
              err_timeout_r <= 1'b1;
              state_r       <= DONE;
              upload_en_r   <= 1'b0;
            end else if (idle_cnt_r != IDLE_MAX) begin
              idle_cnt_r <= idle_cnt_r + IDLE_W'(1'b1);
            end
          end

          GAP: begin
            if (bus.laser_trig) begin
              err_overrun_r <= 1'b1;
            end
            if (gap_cnt_r == GAP_LAST) begin
              state_r <= ARM;
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
            end
          end

          DONE: begin
            run_done_r  <= 1'b1;
            busy_r      <= 1'b0;
            upload_en_r <= 1'b0;
            state_r     <= IDLE;
          end

          default: begin
            state_r     <= IDLE;
            upload_en_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Upload_En     = upload_en_r;
  assign bus.trigger_start = trigger_start_r;
  assign bus.busy          = busy_r;
  assign bus.run_done      = run_done_r;
  assign bus.frames_sent   = frames_sent_r;
  assign bus.err_skip      = err_skip_r;
  assign bus.err_overrun   = err_overrun_r;
  assign bus.err_timeout   = err_timeout_r;

endmodule

// File: tb/tb_upload_sequencer.sv
// ----------------------------------------------------------------------------
// tb_upload_sequencer
//   Randomized runs of the upload sequencer. The stimulus side plans each
//   run from the sequencing rules (frame length, guard gap, timeout) and
//   pushes the cycle at which each trigger_start / run_done must appear,
//   together with the expected status, into queues. A monitor pops and
//   compares whenever the DUT pulses one of those outputs.
// ----------------------------------------------------------------------------
module tb_upload_sequencer;

  localparam int FRAME_LEN  = 8;
  localparam int CNT_W      = 16;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 16;

  typedef struct {
    int t;
    int frames;
    bit skip;
    bit ovr;
    bit tmo;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int    trig_q[$];
  done_t done_q[$];

  // model of the sticky status for the run in progress
  bit e_skip, e_ovr, e_tmo;
  int e_frames;

  upload_sequencer_if #(.CNT_W(CNT_W)) bus ();

  upload_sequencer #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.trigger_start === 1'b1) begin
        if (trig_q.size() == 0) check("unexpected_trigger_start", 1, 0);
        else check("trigger_start_cycle", cyc, trig_q.pop_front());
      end
      if (bus.run_done === 1'b1) begin
        if (done_q.size() == 0) check("unexpected_run_done", 1, 0);
        else begin
          done_t d;
          d = done_q.pop_front();
          check("run_done_cycle", cyc, d.t);
          check("done_frames_sent", bus.frames_sent, d.frames);
          check("done_err_skip", bus.err_skip, d.skip);
          check("done_err_overrun", bus.err_overrun, d.ovr);
          check("done_err_timeout", bus.err_timeout, d.tmo);
          check("done_busy", bus.busy, 0);
        end
      end
    end
  end

  task automatic drive(input logic trig, input logic valid);
    bus.laser_trig   = trig;
    bus.upload_valid = valid;
    @(posedge clk); #1;
    bus.laser_trig   = 1'b0;
    bus.upload_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic push_done(input int t);
    done_t d;
    d.t = t; d.frames = e_frames; d.skip = e_skip; d.ovr = e_ovr; d.tmo = e_tmo;
    done_q.push_back(d);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_upload_en"}, bus.Upload_En, 0);
    check({tag, "_frames_sent"}, bus.frames_sent, e_frames);
    check({tag, "_err_skip"}, bus.err_skip, e_skip);
    check({tag, "_err_overrun"}, bus.err_overrun, e_ovr);
    check({tag, "_err_timeout"}, bus.err_timeout, e_tmo);
  endtask

  // mode: 0 clean, 1 skips/overruns, 2 timeout on one frame, 3 abort mid-upload
  task automatic run_once(input int nframes, input int mode);
    int t, last, nwords, ovr_w, gap_k, abort_f, abort_w, tmo_f;
    e_skip = 0; e_ovr = 0; e_tmo = 0; e_frames = 0;
    bus.frame_num = CNT_W'(nframes);
    bus.run_start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    bus.run_start = 1'b0;
    if (nframes == 0) begin
      push_done(t + 2);
      idle(4);
      check_status("zero_run");
      return;
    end
    check("start_busy", bus.busy, 1);
    check("start_upload_en", bus.Upload_En, 1);
    abort_f = (mode == 3) ? int'($urandom_range(0, nframes - 1)) : -1;
    abort_w = $urandom_range(0, FRAME_LEN - 1);
    tmo_f   = (mode == 2) ? int'($urandom_range(0, nframes - 1)) : -1;
    for (int f = 0; f < nframes; f++) begin
      if (mode == 1) begin
        repeat ($urandom_range(0, 2)) begin
          bus.fifo_prog_full = 1'b1;
          drive(1'b1, 1'b0);
          bus.fifo_prog_full = 1'b0;
          e_skip = 1;
        end
      end
      idle($urandom_range(0, 2));
      t = cyc;
      drive(1'b1, 1'b0);
      trig_q.push_back(t + 1);
      last = t;
      nwords = (f == tmo_f) ? int'($urandom_range(0, FRAME_LEN - 1)) : FRAME_LEN;
      ovr_w  = (mode == 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1;
      for (int w = 0; w < nwords; w++) begin
        idle($urandom_range(0, 2));
        if (f == abort_f && w == abort_w) begin
          bus.run_abort = 1'b1;
          @(posedge clk); #1;
          bus.run_abort = 1'b0;
          check_status("abort");
          idle(TIMEOUT + 4);
          return;
        end
        t = cyc;
        drive(w == ovr_w, 1'b1);
        last = t;
        if (w == ovr_w) e_ovr = 1;
      end
      if (nwords < FRAME_LEN) begin
        // TIMEOUT-1 idle cycles in UPLOAD, one cycle in DONE, then the pulse
        e_tmo = 1;
        push_done(last + TIMEOUT + 1);
        idle(TIMEOUT + 4);
        check_status("timeout_end");
        return;
      end
      e_frames++;
      if (f == nframes - 1) begin
        push_done(last + 2);
        idle(4);
        check_status("run_end");
        return;
      end
      gap_k = (mode == 1) ? int'($urandom_range(0, GAP_CYCLES)) : 0;
      for (int k = 1; k <= GAP_CYCLES; k++) begin
        drive(k == gap_k, 1'b0);
        if (k == gap_k) e_ovr = 1;
      end
    end
  endtask

  initial begin
    bus.run_start = 1'b0; bus.run_abort = 1'b0; bus.frame_num = '0;
    bus.laser_trig = 1'b0; bus.upload_valid = 1'b0; bus.fifo_prog_full = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    e_skip = 0; e_ovr = 0; e_tmo = 0; e_frames = 0;
    check("reset_trigger_start", bus.trigger_start, 0);
    check("reset_run_done", bus.run_done, 0);
    check_status("reset");
    rst = 1'b0;
    idle(2);

    run_once(3, 0);
    run_once(0, 0);
    run_once(2, 1);
    run_once(2, 2);
    run_once(3, 3);
    run_once(2, 0);
    for (int i = 0; i < 12; i++) run_once($urandom_range(1, 4), $urandom_range(0, 3));

    // synchronous reset in the middle of a frame
    bus.frame_num = CNT_W'(2);
    bus.run_start = 1'b1;
    @(posedge clk); #1;
    bus.run_start = 1'b0;
    trig_q.push_back(cyc + 1);
    drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    e_skip = 0; e_ovr = 0; e_tmo = 0; e_frames = 0;
    check("midrst_trigger_start", bus.trigger_start, 0);
    check("midrst_run_done", bus.run_done, 0);
    check_status("midrst");
    rst = 1'b0;
    idle(2);
    run_once(1, 0);

    check("trig_q_leftover", trig_q.size(), 0);
    check("done_q_leftover", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
